// File: rtl/output_port_arbiter.sv
// output_port_arbiter: per-output-port wormhole arbiter for the mesh router.
// Grants one input port round-robin on a HEADER flit and holds the grant
// until that packet's TAIL flit is accepted downstream.
// Optional feature macro: ARB_TIMEOUT_EN. When defined, a stalled packet is
// forcibly released after TIMEOUT stalled cycles.
module output_port_arbiter #(
  parameter int PORTS   = 4,
  parameter int IDX_W   = $clog2(PORTS),
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PORTS-1:0] req_valid,
  input  logic [PORTS-1:0] req_head,
  input  logic [PORTS-1:0] req_tail,
  input  logic             up_ack,
  output logic             up_enable,
  output logic [PORTS-1:0] down_ack,
  output logic [PORTS-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy,
  output logic             proto_err,
  output logic             timeout_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [PORTS-1:0] gnt_q, gnt_d;
  logic             first_done_q, first_done_d;

  logic             cand_any;
  logic [IDX_W-1:0] winner;
  logic             owner_valid, owner_head, owner_tail;
  logic             xfer;
  logic [IDX_W-1:0] next_ptr;
  logic             stall_hit;

  // Round-robin search for a HEADER request, starting at rr_ptr
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    cand_any = 1'b0;
    winner   = '0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < PORTS; k++) begin
      sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(PORTS)) sum = sum - (IDX_W+1)'(PORTS);
      idx = sum[IDX_W-1:0];
      if (!cand_any && req_valid[idx] && req_head[idx]) begin
        cand_any = 1'b1;
        winner   = idx;
      end
    end
  end

  assign owner_valid = req_valid[gnt_idx_q];
  assign owner_head  = req_head[gnt_idx_q];
  assign owner_tail  = req_tail[gnt_idx_q];
  assign xfer        = (state_q == LOCKED) && owner_valid && up_ack;
  assign next_ptr    = (gnt_idx_q == IDX_W'(PORTS-1)) ? '0 : gnt_idx_q + IDX_W'(1);

  assign up_enable = (state_q == LOCKED) && owner_valid;
  assign down_ack  = xfer ? gnt_q : '0;
  assign proto_err = xfer && owner_head && first_done_q;
  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign busy      = (state_q == LOCKED);

`ifdef ARB_TIMEOUT_EN
  logic [15:0] stall_q;
  logic        timeout_q;

  assign stall_hit = (state_q == LOCKED) && !xfer && (stall_q == 16'(TIMEOUT-1));
  assign timeout_o = timeout_q;

  // Count consecutive stalled LOCKED cycles; idle, transfers and releases clear it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= stall_hit;
      if (state_q == IDLE || xfer || stall_hit) stall_q <= '0;
      else                                      stall_q <= stall_q + 16'd1;
    end
  end
`else
  assign stall_hit = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Next-state: grant on a header in IDLE, release on tail transfer or forced timeout
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_d        = gnt_q;
    first_done_d = first_done_q;
    case (state_q)
      IDLE: begin
        if (cand_any) begin
          state_d       = LOCKED;
          gnt_d         = '0;
          gnt_d[winner] = 1'b1;
          gnt_idx_d     = winner;
          first_done_d  = 1'b0;
        end
      end
      LOCKED: begin
        if (xfer) begin
          first_done_d = 1'b1;
          if (owner_tail) begin
            state_d   = IDLE;
            gnt_d     = '0;
            gnt_idx_d = '0;
            rr_ptr_d  = next_ptr;
          end
        end else if (stall_hit) begin
          state_d   = IDLE;
          gnt_d     = '0;
          gnt_idx_d = '0;
          rr_ptr_d  = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      gnt_idx_q    <= '0;
      gnt_q        <= '0;
      first_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_q        <= gnt_d;
      first_done_q <= first_done_d;
    end
  end

endmodule
